// File: rtl/input_buffer_rc.sv
// input_buffer_rc
// Per-input-port flit FIFO with XY route computation for the 2x4 mesh router.
// Stores flits from the upstream link and presents the front flit together
// with its output-port request to the switch allocator. The front flit is
// popped when the router signals a crossbar grant.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream flit present
//   in_flit    in   upstream flit (DATA_W bits, [DATA_W-1:DATA_W-2] = type)
//   in_ready   out  buffer can accept a flit this cycle
//   grant      in   front flit traverses the crossbar this cycle (pop)
//   out_flit   out  front flit of the FIFO
//   dst        out  output-port request (OUT_*_PORT or EMPTY)
//   dst_en     out  one-cycle pulse whenever dst changes value
//   count      out  current occupancy
//   grant_err  out  sticky flag: grant seen while the FIFO was empty

module input_buffer_rc #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int X_W     = 2,
  parameter int Y_W     = 1,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_flit,
  output logic                       in_ready,
  input  logic                       grant,
  output logic [DATA_W-1:0]          out_flit,
  output logic [2:0]                 dst,
  output logic                       dst_en,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       grant_err
);

  // Output-port codes shared with the switch allocator.
  localparam logic [2:0] EMPTY          = 3'd0;
  localparam logic [2:0] OUT_X1_PORT    = 3'd1;
  localparam logic [2:0] OUT_X2_PORT    = 3'd2;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd3;
  localparam logic [2:0] OUT_LOCAL_PORT = 3'd4;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_r;
  logic [2:0]        route_reg;
  logic [2:0]        dst_prev;
  logic              grant_err_r;

  logic              push;
  logic              pop;
  logic [1:0]        front_type;
  logic              front_is_head;
  logic              front_is_tail;
  logic [X_W-1:0]    front_x;
  logic [Y_W-1:0]    front_y;
  logic [2:0]        route_calc;
  logic [2:0]        dst_c;

  assign in_ready = (count_r < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = grant & (count_r != '0);

  assign out_flit = mem[rd_ptr];

  // Type bit 0 marks head/single (route-carrying), bit 1 marks tail/single
  // (packet-closing).
  assign front_type    = out_flit[DATA_W-1 -: 2];
  assign front_is_head = front_type[0];
  assign front_is_tail = front_type[1];
  assign front_x       = out_flit[DATA_W-3 -: X_W];
  assign front_y       = out_flit[DATA_W-3-X_W -: Y_W];

  // Dimension-ordered routing: resolve x first, then y, then eject.
  always_comb begin
    route_calc = OUT_LOCAL_PORT;
    if (front_x < X_W'(LOCAL_X))
      route_calc = OUT_X1_PORT;
    else if (front_x > X_W'(LOCAL_X))
      route_calc = OUT_X2_PORT;
    else if (front_y != Y_W'(LOCAL_Y))
      route_calc = OUT_Y1_PORT;
  end

  // Body and tail flits follow the route latched when their head left.
  always_comb begin
    dst_c = route_reg;
    if (count_r == '0)
      dst_c = EMPTY;
    else if (front_is_head)
      dst_c = route_calc;
  end

  assign dst       = dst_c;
  assign dst_en    = (dst_c != dst_prev);
  assign count     = count_r;
  assign grant_err = grant_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      route_reg   <= EMPTY;
      dst_prev    <= EMPTY;
      grant_err_r <= 1'b0;
    end else begin
      dst_prev <= dst_c;

      if (push) begin
        mem[wr_ptr] <= in_flit;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (front_is_tail)
          route_reg <= EMPTY;
        else if (front_is_head)
          route_reg <= route_calc;
      end

      if (push && !pop)
        count_r <= count_r + CNT_W'(1);
      else if (pop && !push)
        count_r <= count_r - CNT_W'(1);

      if (grant && (count_r == '0))
        grant_err_r <= 1'b1;
    end
  end

endmodule
